mac_loader: RTL and testbench

MAC_LOADER -- requirements
Module: mac_loader

---
 rtl/mac_pkg.sv | 18 +
 rtl/mac_loader.sv | 162 ++++++++++++++++
 tb/tb_mac_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array and its operand loader: default
// geometry/widths and the loader state encoding.
package mac_pkg;

  localparam int MAC_I  = 1;  // log2 tile count
  localparam int MAC_J  = 3;  // log2 lanes per tile
  localparam int MAC_W1 = 3;  // operand width
  localparam int MAC_W2 = 7;  // result width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_READ,
    ST_OUT
  } mac_state_e;

endpackage

// File: rtl/mac_loader.sv
// Streams one frame of A/B operand pairs into the MAC array, waits for the
// array to settle, then reads back one result per tile over a valid/ready port.
module mac_loader
  import mac_pkg::*;
#(
  parameter int I      = MAC_I,
  parameter int J      = MAC_J,
  parameter int W1     = MAC_W1,
  parameter int W2     = MAC_W2,
  parameter int SETTLE = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W1-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W1-1:0] wr_data,
  output logic          a_wren,
  output logic          b_wren,
  output logic [J-1:0]  sel0,
  output logic [I-1:0]  sel1,
  input  logic [W2-1:0] res_in,
  output logic [W2-1:0] res_data,
  output logic [I-1:0]  res_tile,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy,
  output logic          done
);

  // Word index layout: bit 0 = A/B, bits [J:1] = lane, bits [I+J:J+1] = tile.
  localparam int WORD_W = I + J + 1;
  localparam int SW     = (SETTLE < 2) ? 1 : $clog2(SETTLE);

  mac_state_e      state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [I-1:0]    tile_q, tile_d;
  logic [W1-1:0]   wr_data_q, wr_data_d;
  logic            a_wren_q, a_wren_d;
  logic            b_wren_q, b_wren_d;
  logic [J-1:0]    sel0_q, sel0_d;
  logic [I-1:0]    sel1_q, sel1_d;
  logic [W2-1:0]   res_data_q, res_data_d;
  logic [I-1:0]    res_tile_q, res_tile_d;

  logic accept;
  logic last_tile;

  assign accept    = in_valid && (state_q == ST_LOAD);
  assign last_tile = &tile_q;

  // NOTE: every variable gets a default before the case, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    settle_d   = settle_q;
    tile_d     = tile_q;
    wr_data_d  = wr_data_q;
    a_wren_d   = 1'b0;
    b_wren_d   = 1'b0;
    sel0_d     = sel0_q;
    sel1_d     = sel1_q;
    res_data_d = res_data_q;
    res_tile_d = res_tile_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          word_d  = '0;
          tile_d  = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          word_d    = word_q + 1'b1;
          wr_data_d = in_data;
          sel0_d    = word_q[J:1];
          sel1_d    = word_q[WORD_W-1:J+1];
          a_wren_d  = ~word_q[0];
          b_wren_d  = word_q[0];
          if (&word_q) begin
            state_d  = ST_SETTLE;
            settle_d = SW'(SETTLE - 1);
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_READ;
          tile_d  = '0;
          sel1_d  = '0;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_READ: begin
        res_data_d = res_in;
        res_tile_d = tile_q;
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (res_ready) begin
          if (last_tile) begin
            state_d = ST_IDLE;
          end else begin
            tile_d  = tile_q + 1'b1;
            sel1_d  = tile_q + 1'b1;
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      settle_q   <= '0;
      tile_q     <= '0;
      wr_data_q  <= '0;
      a_wren_q   <= 1'b0;
      b_wren_q   <= 1'b0;
      sel0_q     <= '0;
      sel1_q     <= '0;
      res_data_q <= '0;
      res_tile_q <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      settle_q   <= settle_d;
      tile_q     <= tile_d;
      wr_data_q  <= wr_data_d;
      a_wren_q   <= a_wren_d;
      b_wren_q   <= b_wren_d;
      sel0_q     <= sel0_d;
      sel1_q     <= sel1_d;
      res_data_q <= res_data_d;
      res_tile_q <= res_tile_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_OUT);
  assign done      = (state_q == ST_OUT) && res_ready && last_tile;
  assign wr_data   = wr_data_q;
  assign a_wren    = a_wren_q;
  assign b_wren    = b_wren_q;
  assign sel0      = sel0_q;
  assign sel1      = sel1_q;
  assign res_data  = res_data_q;
  assign res_tile  = res_tile_q;

endmodule

// File: tb/tb_mac_loader.sv
// Directed bench for mac_loader with a behavioural 2-tile x 8-lane MAC array.
module tb_mac_loader;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, res_ready;
  logic [2:0] in_data;
  logic       in_ready, a_wren, b_wren, res_valid, busy, done;
  logic [2:0] wr_data, sel0;
  logic [0:0] sel1, res_tile;
  logic [6:0] res_in, res_data;

  int n_checks = 0;
  int n_fail   = 0;

  mac_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_data(wr_data),
    .a_wren(a_wren), .b_wren(b_wren), .sel0(sel0), .sel1(sel1),
    .res_in(res_in), .res_data(res_data), .res_tile(res_tile),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural MAC array: per-lane A/B registers, tile sum truncated to 7 bits.
  logic [2:0] mac_a [2][8];
  logic [2:0] mac_b [2][8];
  logic [9:0] acc;

  always @(posedge clk) begin
    if (a_wren) mac_a[sel1][sel0] <= wr_data;
    if (b_wren) mac_b[sel1][sel0] <= wr_data;
  end

  always_comb begin
    acc = '0;
    for (int l = 0; l < 8; l++) acc = acc + 10'(mac_a[sel1][l]) * 10'(mac_b[sel1][l]);
    res_in = acc[6:0];
  end

  // Operands of the current frame, indexed by slot.
  logic [2:0] op_a [16];
  logic [2:0] op_b [16];

  // Strobe/write monitor.
  logic       acc_prev;
  logic [4:0] exp_word;
  int a_cnt = 0, b_cnt = 0, both_cnt = 0, orphan_cnt = 0, seq_err = 0, done_cnt = 0;
  logic [0:0] s5_sel1;
  logic [2:0] s5_sel0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_prev <= 1'b0;
    else        acc_prev <= in_valid && in_ready;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_word = '0;
    end else begin
      if (a_wren && b_wren) both_cnt++;
      if ((a_wren || b_wren) != acc_prev) orphan_cnt++;
      if (a_wren) a_cnt++;
      if (b_wren) b_cnt++;
      if (done) done_cnt++;
      if (a_wren || b_wren) begin
        if (a_wren !== !exp_word[0] || sel1 !== exp_word[4] || sel0 !== exp_word[3:1] ||
            wr_data !== (exp_word[0] ? op_b[exp_word[4:1]] : op_a[exp_word[4:1]]))
          seq_err++;
        if (exp_word[4:1] == 4'd5 && a_wren) begin
          s5_sel1 = sel1;
          s5_sel0 = sel0;
        end
        exp_word = exp_word + 5'd1;
      end
    end
  end

  logic [6:0] got_data [2];
  logic [0:0] got_tile [2];
  logic       done_at  [2];
  int         stable_err;
  int         settle_wait;

  task automatic set_ops(input logic [2:0] va, input logic [2:0] vb);
    for (int s = 0; s < 16; s++) begin
      op_a[s] = va;
      op_b[s] = vb;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Feeds nwords words; optional one-cycle gap after each word and an extra
  // start pulse alongside word start_at.
  task automatic load_frame(input bit stall, input int nwords, input int start_at);
    bit ok;
    int cyc;
    for (int w = 0; w < nwords; w++) begin
      in_data  = w[0] ? op_b[w >> 1] : op_a[w >> 1];
      in_valid = 1'b1;
      if (w == start_at) start = 1'b1;
      cyc = 0;
      do begin
        ok = in_ready;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end while (!ok && cyc < 20);
      if (!ok) begin
        n_checks++; n_fail++;
        $display("FAIL load_timeout word %0d: in_ready never high", w);
      end
      if (stall && w != nwords - 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Reads both tile results; hold > 0 keeps res_ready low that many cycles in OUT.
  task automatic collect(input int hold);
    int cyc;
    stable_err = 0;
    for (int t = 0; t < 2; t++) begin
      cyc = 0;
      while (!res_valid && cyc < 50) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (t == 0) settle_wait = cyc;
      if (!res_valid) begin
        n_checks++; n_fail++;
        $display("FAIL res_valid_timeout tile %0d", t);
      end
      got_data[t] = res_data;
      got_tile[t] = res_tile;
      if (hold > 0) begin
        res_ready = 1'b0;
        #1;
        repeat (hold) begin
          @(posedge clk); #1;
          if (res_data !== got_data[t] || res_tile !== got_tile[t] || !res_valid) stable_err++;
        end
      end
      res_ready  = 1'b1;
      #1;
      done_at[t] = done;
      @(posedge clk); #1;
      if (hold > 0) res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, a_wren, b_wren, wr_data, sel0, sel1, res_data, res_tile, res_valid, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b in_ready=%b res_valid=%b, need all 0", busy, in_ready, res_valid);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b in_ready=%b, need 0 0", busy, in_ready);
    end
  endtask

  task automatic test_all_ones();
    int a0, b0, both0, orph0, seq0, done0;
    set_ops(3'd1, 3'd1);
    a0 = a_cnt; b0 = b_cnt; both0 = both_cnt; orph0 = orphan_cnt; seq0 = seq_err; done0 = done_cnt;
    res_ready = 1'b1;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ones_load_entry: busy=%b in_ready=%b, need 1 1", busy, in_ready);
    end
    load_frame(1'b0, 32, -1);
    collect(0);
    res_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (got_data[0] !== 7'd8 || got_tile[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ones_tile0: got %0d tile %0d, need 8 tile 0", got_data[0], got_tile[0]);
    end
    n_checks++;
    if (got_data[1] !== 7'd8 || got_tile[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL ones_tile1: got %0d tile %0d, need 8 tile 1", got_data[1], got_tile[1]);
    end
    n_checks++;
    if (settle_wait !== 4) begin
      n_fail++;
      $display("FAIL ones_settle_latency: got %0d cycles, need 4", settle_wait);
    end
    n_checks++;
    if (a_cnt - a0 !== 16 || b_cnt - b0 !== 16) begin
      n_fail++;
      $display("FAIL ones_strobe_count: a=%0d b=%0d, need 16 16", a_cnt - a0, b_cnt - b0);
    end
    n_checks++;
    if (both_cnt - both0 !== 0 || orphan_cnt - orph0 !== 0) begin
      n_fail++;
      $display("FAIL ones_strobe_timing: both=%0d orphan=%0d, need 0 0", both_cnt - both0, orphan_cnt - orph0);
    end
    n_checks++;
    if (seq_err - seq0 !== 0) begin
      n_fail++;
      $display("FAIL ones_write_order: %0d bad writes, need 0", seq_err - seq0);
    end
    n_checks++;
    if (done_cnt - done0 !== 1 || done_at[0] !== 1'b0 || done_at[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL ones_done: pulses=%0d at0=%b at1=%b, need 1 0 1", done_cnt - done0, done_at[0], done_at[1]);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ones_idle_end: busy=%b, need 0", busy);
    end
  endtask

  task automatic test_all_sevens();
    set_ops(3'd7, 3'd7);
    res_ready = 1'b1;
    pulse_start();
    load_frame(1'b0, 32, -1);
    collect(0);
    res_ready = 1'b0;
    n_checks++;
    if (got_data[0] !== 7'd8 || got_data[1] !== 7'd8) begin
      n_fail++;
      $display("FAIL sevens_truncation: got %0d %0d, need 8 8", got_data[0], got_data[1]);
    end
  endtask

  task automatic test_slot5();
    set_ops(3'd0, 3'd0);
    op_a[5] = 3'd3;
    op_b[5] = 3'd5;
    s5_sel1 = 1'b1;
    s5_sel0 = 3'd0;
    res_ready = 1'b1;
    pulse_start();
    load_frame(1'b0, 32, -1);
    collect(0);
    res_ready = 1'b0;
    n_checks++;
    if (got_data[0] !== 7'd15 || got_data[1] !== 7'd0) begin
      n_fail++;
      $display("FAIL slot5_results: got %0d %0d, need 15 0", got_data[0], got_data[1]);
    end
    n_checks++;
    if (s5_sel1 !== 1'b0 || s5_sel0 !== 3'd5) begin
      n_fail++;
      $display("FAIL slot5_select: got sel1=%0d sel0=%0d, need 0 5", s5_sel1, s5_sel0);
    end
  endtask

  task automatic test_stalls();
    int seq0;
    set_ops(3'd1, 3'd1);
    seq0 = seq_err;
    res_ready = 1'b0;
    pulse_start();
    load_frame(1'b1, 32, -1);
    collect(10);
    n_checks++;
    if (got_data[0] !== 7'd8 || got_data[1] !== 7'd8 || got_tile[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_results: got %0d %0d tile %0d, need 8 8 tile 1", got_data[0], got_data[1], got_tile[1]);
    end
    n_checks++;
    if (stable_err !== 0) begin
      n_fail++;
      $display("FAIL stall_hold_stable: %0d unstable cycles, need 0", stable_err);
    end
    n_checks++;
    if (seq_err - seq0 !== 0 || settle_wait !== 4) begin
      n_fail++;
      $display("FAIL stall_order: bad writes %0d settle %0d, need 0 4", seq_err - seq0, settle_wait);
    end
  endtask

  task automatic test_start_and_reset();
    int seq0;
    set_ops(3'd1, 3'd1);
    seq0 = seq_err;
    pulse_start();
    load_frame(1'b0, 11, 3);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || seq_err - seq0 !== 0) begin
      n_fail++;
      $display("FAIL extra_start: busy=%b in_ready=%b bad writes %0d, need 1 1 0", busy, in_ready, seq_err - seq0);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, a_wren, b_wren, wr_data, sel0, sel1, res_data, res_tile, res_valid, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset_outputs: wr_data=%0d sel0=%0d busy=%b, need all 0", wr_data, sel0, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_to_idle: busy=%b, need 0", busy);
    end
    seq0 = seq_err;
    res_ready = 1'b1;
    pulse_start();
    load_frame(1'b0, 32, -1);
    collect(0);
    res_ready = 1'b0;
    n_checks++;
    if (got_data[0] !== 7'd8 || got_data[1] !== 7'd8 || seq_err - seq0 !== 0) begin
      n_fail++;
      $display("FAIL fresh_frame: got %0d %0d bad writes %0d, need 8 8 0", got_data[0], got_data[1], seq_err - seq0);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_all_sevens();
    test_slot5();
    test_stalls();
    test_start_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
